// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the commit-stage trap controller: instruction encodings,
// int_type codes, mcause values, CSR addresses, FSM state and trap-kind encodings.
package trap_ctrl_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [4:0] INT_NONE   = 5'b00000;
  localparam logic [4:0] INT_ECALL  = 5'b00010;
  localparam logic [4:0] INT_EBREAK = 5'b00100;
  localparam logic [4:0] INT_SWI    = 5'b00011;
  localparam logic [4:0] INT_TIMER  = 5'b00101;
  localparam logic [4:0] INT_PLIC   = 5'b01001;
  localparam logic [4:0] INT_DEBUG  = 5'b10001;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_SWI    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_PLIC   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_DEBUG  = 32'h8000_001F;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_SYNC,
    TRAP_ASYNC,
    TRAP_MRET
  } trap_kind_e;

  // Trap entry: stash MIE into MPIE and disable interrupts.
  function automatic logic [31:0] mstatus_enter(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_exit(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: prioritises ECALL/EBREAK/MRET and async interrupts,
// sequences mepc/mcause/mstatus writes, then redirects fetch. Option macro: TRAP_DEBUG_EN.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned NUM = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [31:0]     inst_addr_i,
  input  logic            jump_flag_i,
  input  logic [31:0]     jump_addr_i,
  input  logic            swi_i,
  input  logic            timer_i,
  input  logic            plic_i,
`ifdef TRAP_DEBUG_EN
  input  logic            debug_req_i,
`endif
  input  logic            global_int_en_i,
  input  logic [31:0]     csr_mtvec_i,
  input  logic [31:0]     csr_mepc_i,
  input  logic [31:0]     csr_mstatus_i,
  output logic            commit_wen_o,
  output logic [31:0]     commit_waddr_o,
  output logic [31:0]     commit_wdata_o,
  output logic [NUM-1:0]  int_type_o,
  output logic            hold_flag_o,
  output logic            int_assert_o,
  output logic [31:0]     int_addr_o
);

  state_e          r_state;
  logic [NUM-1:0]  r_type;
  logic [31:0]     r_cause;
  logic            r_wen;
  logic [31:0]     r_waddr;
  logic [31:0]     r_wdata;
  logic            r_assert;
  logic [31:0]     r_int_addr;

  trap_kind_e      w_kind;
  logic [4:0]      w_type;
  logic [31:0]     w_cause;
  logic [31:0]     w_mepc;
  logic            w_detect;
  logic            w_debug;

`ifdef TRAP_DEBUG_EN
  assign w_debug = debug_req_i;
`else
  assign w_debug = 1'b0;
`endif

  // Priority encoder, evaluated only while idle so mid-sequence requests wait.
  always_comb begin
    w_kind  = TRAP_NONE;
    w_type  = INT_NONE;
    w_cause = '0;
    if (r_state == S_IDLE) begin
      if (w_debug) begin
        w_kind  = TRAP_ASYNC;
        w_type  = INT_DEBUG;
        w_cause = CAUSE_DEBUG;
      end else if (inst_i == INST_MRET) begin
        w_kind  = TRAP_MRET;
      end else if (inst_i == INST_ECALL) begin
        w_kind  = TRAP_SYNC;
        w_type  = INT_ECALL;
        w_cause = CAUSE_ECALL;
      end else if (inst_i == INST_EBREAK) begin
        w_kind  = TRAP_SYNC;
        w_type  = INT_EBREAK;
        w_cause = CAUSE_EBREAK;
      end else if (global_int_en_i && plic_i) begin
        w_kind  = TRAP_ASYNC;
        w_type  = INT_PLIC;
        w_cause = CAUSE_PLIC;
      end else if (global_int_en_i && swi_i) begin
        w_kind  = TRAP_ASYNC;
        w_type  = INT_SWI;
        w_cause = CAUSE_SWI;
      end else if (global_int_en_i && timer_i) begin
        w_kind  = TRAP_ASYNC;
        w_type  = INT_TIMER;
        w_cause = CAUSE_TIMER;
      end
    end
  end

  // An async trap must resume at the taken branch target, not the branch itself.
  assign w_mepc   = (w_kind == TRAP_ASYNC && jump_flag_i) ? jump_addr_i : inst_addr_i;
  assign w_detect = (w_kind != TRAP_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_type     <= '0;
      r_cause    <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_assert   <= 1'b0;
      r_int_addr <= '0;
    end else begin
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_assert   <= 1'b0;
      r_int_addr <= '0;
      unique case (r_state)
        S_IDLE: begin
          r_type <= '0;
          if (w_kind == TRAP_SYNC || w_kind == TRAP_ASYNC) begin
            r_state <= S_W_MEPC;
            r_type  <= NUM'(w_type);
            r_cause <= w_cause;
            r_wen   <= 1'b1;
            r_waddr <= CSR_MEPC;
            r_wdata <= w_mepc;
          end else if (w_kind == TRAP_MRET) begin
            r_state <= S_W_MRET;
            r_wen   <= 1'b1;
            r_waddr <= CSR_MSTATUS;
            r_wdata <= mstatus_exit(csr_mstatus_i);
          end
        end
        S_W_MEPC: begin
          r_state <= S_W_MCAUSE;
          r_wen   <= 1'b1;
          r_waddr <= CSR_MCAUSE;
          r_wdata <= r_cause;
        end
        S_W_MCAUSE: begin
          r_state <= S_W_MSTATUS;
          r_wen   <= 1'b1;
          r_waddr <= CSR_MSTATUS;
          r_wdata <= mstatus_enter(csr_mstatus_i);
        end
        S_W_MSTATUS: begin
          r_state    <= S_ASSERT;
          r_assert   <= 1'b1;
          r_int_addr <= csr_mtvec_i;
        end
        S_W_MRET: begin
          r_state    <= S_ASSERT;
          r_assert   <= 1'b1;
          r_int_addr <= csr_mepc_i;
        end
        S_ASSERT: begin
          r_state <= S_IDLE;
          r_type  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_type  <= '0;
        end
      endcase
    end
  end

  assign hold_flag_o    = w_detect | (r_state != S_IDLE);
  assign commit_wen_o   = r_wen;
  assign commit_waddr_o = r_waddr;
  assign commit_wdata_o = r_wdata;
  assign int_type_o     = r_type;
  assign int_assert_o   = r_assert;
  assign int_addr_o     = r_int_addr;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: a per-cycle queue of expected commit/redirect
// activity is planned from the trap rules; a small CSR environment feeds the DUT.
module tb_trap_ctrl;

  localparam int unsigned NUM = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, swi_i, timer_i, plic_i;
`ifdef TRAP_DEBUG_EN
  logic        debug_req_i;
`endif
  logic        global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        commit_wen_o;
  logic [31:0] commit_waddr_o, commit_wdata_o;
  logic [NUM-1:0] int_type_o;
  logic        hold_flag_o, int_assert_o;
  logic [31:0] int_addr_o;

  trap_ctrl #(.NUM(NUM)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .swi_i(swi_i), .timer_i(timer_i), .plic_i(plic_i),
`ifdef TRAP_DEBUG_EN
    .debug_req_i(debug_req_i),
`endif
    .global_int_en_i(global_int_en_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .commit_wen_o(commit_wen_o), .commit_waddr_o(commit_waddr_o),
    .commit_wdata_o(commit_wdata_o), .int_type_o(int_type_o),
    .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [4:0]  typ;
    logic        as;
    logic [31:0] iaddr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] env_mstatus, env_mepc, env_mcause, env_mtvec;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_env();
    csr_mstatus_i   = env_mstatus;
    csr_mepc_i      = env_mepc;
    csr_mtvec_i     = env_mtvec;
    global_int_en_i = env_mstatus[3];
  endtask

  // One clock: check this cycle's outputs, plan any newly detected trap, advance the CSRs.
  task automatic step();
    exp_t        cur;
    bit          idle, det, async_t, is_mret, dbg;
    logic [4:0]  t;
    logic [31:0] cause, mepc_v, ms;
    @(negedge clk);
    idle = (q.size() == 0);
    cur  = idle ? exp_t'(0) : q.pop_front();
    det = 0; async_t = 0; is_mret = 0; t = 0; cause = 0;
    dbg = 0;
`ifdef TRAP_DEBUG_EN
    dbg = debug_req_i;
`endif
    ms = env_mstatus;
    if (idle) begin
      det = 1;
      if (dbg)                          begin t = 5'b10001; cause = 32'h8000001F; async_t = 1; end
      else if (inst_i == 32'h30200073)  is_mret = 1;
      else if (inst_i == 32'h00000073)  begin t = 5'b00010; cause = 32'd11; end
      else if (inst_i == 32'h00100073)  begin t = 5'b00100; cause = 32'd3; end
      else if (ms[3] && plic_i)         begin t = 5'b01001; cause = 32'h8000000B; async_t = 1; end
      else if (ms[3] && swi_i)          begin t = 5'b00011; cause = 32'h80000003; async_t = 1; end
      else if (ms[3] && timer_i)        begin t = 5'b00101; cause = 32'h80000007; async_t = 1; end
      else det = 0;
    end
    chk("wen",      {31'b0, commit_wen_o}, {31'b0, cur.wen});
    chk("waddr",    commit_waddr_o,        cur.waddr);
    chk("wdata",    commit_wdata_o,        cur.wdata);
    chk("int_type", {27'b0, int_type_o},   {27'b0, cur.typ});
    chk("assert",   {31'b0, int_assert_o}, {31'b0, cur.as});
    chk("int_addr", int_addr_o,            cur.iaddr);
    chk("hold",     {31'b0, hold_flag_o},  {31'b0, (det | !idle)});
    if (rst) begin
      q.delete();
    end else if (det && is_mret) begin
      q.push_back('{1'b1, 32'h300, (ms | 32'h88) & ~(ms[7] ? 32'h0 : 32'h8), 5'd0, 1'b0, 32'h0});
      q.push_back('{1'b0, 32'h0, 32'h0, 5'd0, 1'b1, env_mepc});
    end else if (det) begin
      mepc_v = (async_t && jump_flag_i) ? jump_addr_i : inst_addr_i;
      q.push_back('{1'b1, 32'h341, mepc_v, t, 1'b0, 32'h0});
      q.push_back('{1'b1, 32'h342, cause,  t, 1'b0, 32'h0});
      q.push_back('{1'b1, 32'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0), t, 1'b0, 32'h0});
      q.push_back('{1'b0, 32'h0, 32'h0, t, 1'b1, env_mtvec});
    end
    @(posedge clk);
    if (cur.wen) begin
      case (cur.waddr)
        32'h341: env_mepc    = cur.wdata;
        32'h342: env_mcause  = cur.wdata;
        32'h300: env_mstatus = cur.wdata;
        default: ;
      endcase
    end
    #1;
    drive_env();
  endtask

  task automatic quiet();
    inst_i = 32'h13; jump_flag_i = 0; swi_i = 0; timer_i = 0; plic_i = 0;
`ifdef TRAP_DEBUG_EN
    debug_req_i = 0;
`endif
  endtask

  initial begin
    rst = 1; quiet();
    inst_addr_i = 32'h0; jump_addr_i = 32'h0;
    env_mstatus = 32'h0; env_mepc = 32'h0; env_mcause = 32'h0; env_mtvec = 32'h2c4;
    drive_env();
    repeat (2) @(posedge clk);
    #1;
    step();                                   // reset state: everything 0
    rst = 0;
    step();

    // ECALL @0x100, mstatus 0x88, mtvec 0x2c4
    env_mstatus = 32'h88; drive_env();
    inst_i = 32'h73; inst_addr_i = 32'h100;
    step(); quiet(); repeat (5) step();

    // timer with interrupts disabled, then enabled
    env_mstatus = 32'h0; drive_env();
    timer_i = 1; repeat (3) step();
    env_mstatus = 32'h88; drive_env();
    repeat (6) step(); quiet(); step();

    // MRET with mstatus 0x80, mepc 0x104
    env_mstatus = 32'h80; env_mepc = 32'h104; drive_env();
    inst_i = 32'h30200073; step(); quiet(); repeat (3) step();

    // PLIC and timer together while a jump is taken
    env_mstatus = 32'h88; drive_env();
    plic_i = 1; timer_i = 1; jump_flag_i = 1; jump_addr_i = 32'h200; inst_addr_i = 32'h1f0;
    step(); quiet(); repeat (5) step();

    // ECALL with PLIC pending: ECALL first, PLIC after return
    env_mstatus = 32'h88; drive_env();
    plic_i = 1; inst_i = 32'h73; inst_addr_i = 32'h300;
    step(); inst_i = 32'h13; repeat (6) step();
    inst_i = 32'h30200073; step(); inst_i = 32'h13; repeat (8) step();
    quiet(); step();

    // reset during W_MCAUSE aborts the sequence
    env_mstatus = 32'h88; drive_env();
    inst_i = 32'h00100073; inst_addr_i = 32'h400;
    step(); quiet(); step();
    rst = 1; step(); rst = 0;
    repeat (4) step();

`ifdef TRAP_DEBUG_EN
    env_mstatus = 32'h0; drive_env();
    debug_req_i = 1; inst_i = 32'h73;
    step(); quiet(); repeat (5) step();
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      if (q.size() == 0) begin
        if ($urandom_range(0, 9) == 0) env_mtvec = $urandom & 32'hffff_fffc;
        if ($urandom_range(0, 19) == 0) env_mstatus = $urandom;
        drive_env();
      end
      r = $urandom_range(0, 19);
      case (r)
        0:       inst_i = 32'h00000073;
        1:       inst_i = 32'h00100073;
        2, 3:    inst_i = 32'h30200073;
        4:       inst_i = $urandom;
        default: inst_i = 32'h13;
      endcase
      inst_addr_i = $urandom & 32'hffff_fffc;
      jump_flag_i = $urandom_range(0, 1) == 1;
      jump_addr_i = $urandom & 32'hffff_fffc;
      swi_i   = $urandom_range(0, 7) == 0;
      timer_i = $urandom_range(0, 7) == 0;
      plic_i  = $urandom_range(0, 7) == 0;
`ifdef TRAP_DEBUG_EN
      debug_req_i = $urandom_range(0, 15) == 0;
`endif
      rst = $urandom_range(0, 79) == 0;
      step();
    end
    rst = 0; quiet();
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
